// File: rtl/piso_pkg.sv
// piso_pkg: shared state type, direction codes and frame sizing for piso_serializer.
// Build option: PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

   function automatic int frame_len(input int msb);
`ifdef PISO_PARITY_EN
      return msb + 1;
`else
      return msb;
`endif
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable up-counter of emitted frame bits.
// last is high while the count equals TERM; the count saturates there.
module piso_bit_counter #(
   parameter int W    = 3,
   parameter int TERM = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         last
);

   localparam logic [W-1:0] TERM_C = W'(TERM);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (load) begin
            cnt_d = W'(1);
         end else if (clr) begin
            cnt_d = '0;
         end else if (inc && (cnt_q != TERM_C)) begin
            cnt_d = cnt_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == TERM_C);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load, per-word direction.
// Build option: PISO_PARITY_EN emits an even-parity bit after the data bits.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int MSB = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic [MSB-1:0] load_data,
   input  logic           load_dir,
   output logic           q,
   output logic           q_valid,
   output logic           q_last,
   output logic           busy
);

   localparam int FLEN = frame_len(MSB);
   localparam int CW   = $clog2(FLEN + 1);

   state_e         state_q;
   state_e         state_d;
   logic [MSB-1:0] sr_q;
   logic [MSB-1:0] sr_d;
   logic           dir_q;
   logic           dir_d;
   logic           q_q;
   logic           q_d;
   logic [CW-1:0]  cnt;
   logic           last;
   logic           accept;
   logic           step;
   logic           clr;
`ifdef PISO_PARITY_EN
   logic           par_q;
   logic           par_d;
`else
   logic           cnt_unused;
   assign cnt_unused = ^cnt;
`endif

   // Ready on the last bit too, so the next frame follows without a gap
   assign load_ready = !rst && en &&
                       ((state_q == IDLE) || ((state_q == SHIFT) && last));
   assign accept     = load_valid && load_ready;
   assign step       = en && (state_q == SHIFT) && !last;
   assign clr        = en && (state_q == SHIFT) && last && !accept;

   piso_bit_counter #(
      .W    (CW),
      .TERM (FLEN)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .load (accept),
      .clr  (clr),
      .inc  (state_q == SHIFT),
      .cnt  (cnt),
      .last (last)
   );

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      dir_d   = dir_q;
      q_d     = q_q;
`ifdef PISO_PARITY_EN
      par_d   = par_q;
`endif
      if (accept) begin
         state_d = SHIFT;
         dir_d   = load_dir;
`ifdef PISO_PARITY_EN
         par_d   = ^load_data;
`endif
         // First bit goes straight to q; sr keeps the remainder
         if (load_dir == DIR_LSB_FIRST) begin
            q_d  = load_data[0];
            sr_d = load_data >> 1;
         end else begin
            q_d  = load_data[MSB-1];
            sr_d = load_data << 1;
         end
      end else if (step) begin
         if (dir_q == DIR_LSB_FIRST) begin
            q_d  = sr_q[0];
            sr_d = sr_q >> 1;
         end else begin
            q_d  = sr_q[MSB-1];
            sr_d = sr_q << 1;
         end
`ifdef PISO_PARITY_EN
         if (cnt == CW'(MSB)) begin
            q_d = par_q;
         end
`endif
      end else if (clr) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         dir_q   <= DIR_MSB_FIRST;
         q_q     <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         dir_q   <= dir_d;
         q_q     <= q_d;
`ifdef PISO_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign q       = q_q;
   assign q_valid = (state_q == SHIFT);
   assign busy    = (state_q == SHIFT);
   assign q_last  = (state_q == SHIFT) && last;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed spec scenarios plus a randomized run against a bit-queue model.
// Define PISO_PARITY_EN to check the parity-bit build.
module tb_piso_serializer;
   import piso_pkg::*;

   localparam int MSB = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = MSB + 1;
`else
   localparam int FL = MSB;
`endif

   typedef bit bitq_t[$];

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic           load_valid;
   logic           load_ready;
   logic [MSB-1:0] load_data;
   logic           load_dir;
   logic           q;
   logic           q_valid;
   logic           q_last;
   logic           busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(.MSB(MSB)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_dir   (load_dir),
      .q          (q),
      .q_valid    (q_valid),
      .q_last     (q_last),
      .busy       (busy)
   );

   // Reference: the bits a frame puts on the wire, in order
   function automatic bitq_t frame_bits(input logic [MSB-1:0] d, input logic dir);
      bitq_t b;
      for (int i = 0; i < MSB; i++) begin
         b.push_back(dir ? d[i] : d[MSB-1-i]);
      end
`ifdef PISO_PARITY_EN
      b.push_back(^d);
`endif
      return b;
   endfunction

   task automatic drive(input logic r, input logic e, input logic v,
                        input logic [MSB-1:0] d, input logic dr);
      rst        = r;
      en         = e;
      load_valid = v;
      load_data  = d;
      load_dir   = dr;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 1'b1, 4'b1011, DIR_MSB_FIRST);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready cyc=%0d got=%b exp=0", i, load_ready);
         end
         checks++;
         if ({q_valid, q, busy, q_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs cyc=%0d got=%b exp=0000", i,
                     {q_valid, q, busy, q_last});
         end
      end
      drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
      @(negedge clk);
   endtask

   task automatic test_msb_first();
      bitq_t exp = '{1, 0, 1, 1};
`ifdef PISO_PARITY_EN
      exp.push_back(1);
`endif
      drive(1'b0, 1'b1, 1'b1, 4'b1011, DIR_MSB_FIRST);
      #1;
      checks++;
      if (load_ready !== 1'b1) begin
         errors++;
         $display("FAIL msb_ready got=%b exp=1", load_ready);
      end
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         checks++;
         if ({q_valid, busy, q, q_last} !== {2'b11, exp[i], 1'(i == FL - 1)}) begin
            errors++;
            $display("FAIL msb_bit i=%0d got=%b exp=%b", i, {q_valid, busy, q, q_last},
                     {2'b11, exp[i], 1'(i == FL - 1)});
         end
      end
      @(negedge clk);
      checks++;
      if ({q_valid, busy, q_last} !== 3'b000) begin
         errors++;
         $display("FAIL msb_idle got=%b exp=000", {q_valid, busy, q_last});
      end
   endtask

   task automatic test_lsb_first();
      bitq_t          exp = '{1, 1, 0, 1};
      logic [MSB-1:0] rx  = '0;
`ifdef PISO_PARITY_EN
      exp.push_back(1);
`endif
      drive(1'b0, 1'b1, 1'b1, 4'b1011, DIR_LSB_FIRST);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         checks++;
         if ({q_valid, q, q_last} !== {1'b1, exp[i], 1'(i == FL - 1)}) begin
            errors++;
            $display("FAIL lsb_bit i=%0d got=%b exp=%b", i, {q_valid, q, q_last},
                     {1'b1, exp[i], 1'(i == FL - 1)});
         end
         if (i < MSB) rx = {q, rx[MSB-1:1]};
      end
      checks++;
      if (rx !== 4'b1011) begin
         errors++;
         $display("FAIL lsb_loopback got=%b exp=1011", rx);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bitq_t exp = frame_bits(4'b1011, DIR_MSB_FIRST);
      bitq_t two = frame_bits(4'b0110, DIR_MSB_FIRST);
      exp = {exp, two};
      drive(1'b0, 1'b1, 1'b1, 4'b1011, DIR_MSB_FIRST);
      for (int i = 0; i < 2 * FL; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b0, 1'b1, 1'b1, 4'b0110, DIR_MSB_FIRST);
         if (i == FL) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         checks++;
         if ({q_valid, q, q_last, load_ready} !==
             {1'b1, exp[i], 1'(i == FL - 1 || i == 2 * FL - 1),
              1'(i == FL - 1 || i == 2 * FL - 1)}) begin
            errors++;
            $display("FAIL b2b_bit i=%0d got=%b exp=%b", i, {q_valid, q, q_last, load_ready},
                     {1'b1, exp[i], 1'(i == FL - 1 || i == 2 * FL - 1),
                      1'(i == FL - 1 || i == 2 * FL - 1)});
         end
      end
      @(negedge clk);
      checks++;
      if (q_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle got=%b exp=0", q_valid);
      end
   endtask

   task automatic test_enable_stall();
      bitq_t exp = frame_bits(4'b1011, DIR_MSB_FIRST);
      int    k;
      drive(1'b0, 1'b1, 1'b1, 4'b1011, DIR_MSB_FIRST);
      for (int c = 0; c < FL + 2; c++) begin
         @(negedge clk);
         if (c == 0) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         k = (c < 2) ? c : ((c < 4) ? 1 : c - 2);
         checks++;
         if ({q_valid, q, q_last} !== {1'b1, exp[k], 1'(k == FL - 1)}) begin
            errors++;
            $display("FAIL stall_bit c=%0d got=%b exp=%b", c, {q_valid, q, q_last},
                     {1'b1, exp[k], 1'(k == FL - 1)});
         end
         if (c == 2 || c == 3) begin
            checks++;
            if (load_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_ready c=%0d got=%b exp=0", c, load_ready);
            end
         end
         if (c == 1) en = 1'b0;
         if (c == 3) en = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 1'b1, 4'b1011, DIR_MSB_FIRST);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            checks++;
            if ({q_valid, busy, q_last, q, load_ready} !== {4'b0000, 1'(c != 2)}) begin
               errors++;
               $display("FAIL rst_mid c=%0d got=%b exp=%b", c,
                        {q_valid, busy, q_last, q, load_ready}, {4'b0000, 1'(c != 2)});
            end
         end
         if (c == 0) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         if (c == 1) drive(1'b1, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         if (c == 2) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
      end
   endtask

`ifdef PISO_PARITY_EN
   task automatic test_parity();
      bitq_t exp = '{0, 1, 1, 0, 0};
      drive(1'b0, 1'b1, 1'b1, 4'b0110, DIR_MSB_FIRST);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i == 0) drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
         checks++;
         if ({q_valid, q, q_last} !== {1'b1, exp[i], 1'(i == FL - 1)}) begin
            errors++;
            $display("FAIL parity_bit i=%0d got=%b exp=%b", i, {q_valid, q, q_last},
                     {1'b1, exp[i], 1'(i == FL - 1)});
         end
      end
      @(negedge clk);
   endtask
`endif

   task automatic test_random();
      bitq_t          cur;
      bit             held;
      logic           r;
      logic           e;
      logic           v;
      logic           dr;
      logic           exp_rdy;
      logic [MSB-1:0] d;
      logic [3:0]     exp_o;
      drive(1'b1, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
      @(negedge clk);
      held = 1'b0;
      for (int n = 0; n < 800; n++) begin
         if (cur.size() > 0) exp_o = {2'b11, cur[0], 1'(cur.size() == 1)};
         else exp_o = {3'b000, held};
         if (cur.size() == 0) exp_o = {2'b00, 1'b0, held};
         checks++;
         if ({q_valid, busy, q_last, q} !== ((cur.size() > 0) ?
             {2'b11, 1'(cur.size() == 1), cur[0]} : {3'b000, held})) begin
            errors++;
            $display("FAIL rand_out n=%0d got=%b exp=%b", n, {q_valid, busy, q_last, q},
                     (cur.size() > 0) ? {2'b11, 1'(cur.size() == 1), cur[0]} : {3'b000, held});
         end
         r  = ($urandom_range(63) == 0);
         e  = ($urandom_range(99) < 85);
         v  = ($urandom_range(99) < 60);
         d  = MSB'($urandom);
         dr = 1'($urandom);
         drive(r, e, v, d, dr);
         exp_rdy = !r && e && (cur.size() <= 1);
         #1;
         checks++;
         if (load_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rand_ready n=%0d got=%b exp=%b", n, load_ready, exp_rdy);
         end
         if (r) begin
            cur.delete();
            held = 1'b0;
         end else if (e) begin
            if (v && exp_rdy) begin
               cur = frame_bits(d, dr);
            end else if (cur.size() > 0) begin
               held = cur.pop_front();
            end
         end
         @(negedge clk);
      end
      drive(1'b0, 1'b1, 1'b0, '0, DIR_MSB_FIRST);
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_back_to_back();
      test_enable_stall();
      test_reset_mid();
`ifdef PISO_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
